// File: rtl/cic_pkg.sv
`default_nettype none
// ==== cic_pkg : CIC bit-growth helpers shared by interpolator/decimator (rev 1.0) ====
package cic_pkg;

  function automatic int cic_acc_width(input int width, input int stages, input int rate);
    return width + stages * $clog2(rate);
  endfunction

  // Interpolator DC gain is RATE^(STAGES-1); this shift removes it exactly.
  function automatic int cic_interp_shift(input int stages, input int rate);
    return (stages - 1) * $clog2(rate);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cic_integrator_stage.sv
`default_nettype none
// ==== cic_integrator_stage : one modular accumulator of the integrator chain (rev 1.0) ====
module cic_integrator_stage #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] din,
  output logic [ACC_W-1:0] dout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (en) begin
      dout <= dout + din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cic_interpolator.sv
`default_nettype none
// ==== cic_interpolator : unity-gain CIC interpolator, RATE outputs per accepted sample (rev 1.0) ====
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1,
  parameter int RATE   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  localparam int ACC_W = cic_acc_width(WIDTH, STAGES, RATE);
  localparam int SHIFT = cic_interp_shift(STAGES, RATE);
  localparam int PH_W  = $clog2(RATE);

  logic [PH_W-1:0]  phase;
  logic             advance;
  logic             accept;
  logic [ACC_W-1:0] comb_in  [0:STAGES-1];
  logic [ACC_W-1:0] comb_out;
  logic [ACC_W-1:0] dly      [0:STAGES-1];
  logic [ACC_W-1:0] s;
  logic [ACC_W-1:0] integ    [0:STAGES-1];
  logic             unused_acc;

  assign in_ready = (phase == '0) && !rst;
  assign advance  = (phase != '0) || in_valid;
  assign accept   = in_ready && in_valid;

  always_comb begin
    logic [ACC_W-1:0] c;
    c = {{(ACC_W-WIDTH){in[WIDTH-1]}}, in};
    for (int k = 0; k < STAGES; k++) begin
      comb_in[k] = c;
      c          = c - dly[k];
    end
    comb_out = c;
  end

  // RATE is a power of two, so the phase counter wraps by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= '0;
      s         <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      for (int k = 0; k < STAGES; k++) dly[k] <= '0;
    end else begin
      out_valid <= advance;
      if (advance) begin
        phase <= phase + 1'b1;
        out   <= integ[STAGES-1][SHIFT +: WIDTH];
      end
      if (accept) begin
        s <= comb_out;
        for (int k = 0; k < STAGES; k++) dly[k] <= comb_in[k];
      end else if (advance) begin
        s <= '0;
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_integ
    logic [ACC_W-1:0] stage_din;
    if (k == 0) begin : g_first
      assign stage_din = s;
    end else begin : g_chain
      assign stage_din = integ[k-1];
    end
    cic_integrator_stage #(
      .ACC_W(ACC_W)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (advance),
      .din (stage_din),
      .dout(integ[k])
    );
  end

  assign unused_acc = ^integ[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_cic_interpolator.sv
`default_nettype none
// ==== tb_cic_interpolator : three configurations against a convolution reference (rev 1.0) ====
module tb_cic_interpolator;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic [7:0] dout [NI];
  logic       dval [NI];
  logic       drdy [NI];

  always #5 clk = ~clk;

  cic_interpolator #(.WIDTH(8), .STAGES(1), .RATE(4)) u_s1r4 (
    .clk(clk), .rst(rst), .in(din), .in_valid(din_valid),
    .in_ready(drdy[0]), .out(dout[0]), .out_valid(dval[0]));
  cic_interpolator #(.WIDTH(8), .STAGES(2), .RATE(4)) u_s2r4 (
    .clk(clk), .rst(rst), .in(din), .in_valid(din_valid),
    .in_ready(drdy[1]), .out(dout[1]), .out_valid(dval[1]));
  cic_interpolator #(.WIDTH(8), .STAGES(3), .RATE(8)) u_s3r8 (
    .clk(clk), .rst(rst), .in(din), .in_valid(din_valid),
    .in_ready(drdy[2]), .out(dout[2]), .out_valid(dval[2]));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int stg_of(input int i);  return i + 1;            endfunction
  function automatic int rate_of(input int i); return (i == 2) ? 8 : 4; endfunction
  function automatic int lg_of(input int i);   return (i == 2) ? 3 : 2; endfunction

  // Reference: zero-stuffed input convolved with a boxcar of length RATE, STAGES times,
  // delayed by STAGES+1 advance cycles, wrapped to the internal width, then scaled.
  longint h     [NI][32];
  int     hlen  [NI];
  longint hist  [NI][64];
  int     ph    [NI];
  int     t     [NI];
  longint exp_out [NI];
  bit     exp_val [NI];
  int     accepts [NI];
  int     beats   [NI];

  task automatic build_h();
    for (int i = 0; i < NI; i++) begin
      longint a [32];
      longint b [32];
      int len;
      for (int j = 0; j < 32; j++) a[j] = 0;
      a[0] = 1;
      len  = 1;
      for (int n = 0; n < stg_of(i); n++) begin
        for (int j = 0; j < 32; j++) b[j] = 0;
        for (int j = 0; j < len; j++)
          for (int r = 0; r < rate_of(i); r++) b[j+r] += a[j];
        len += rate_of(i) - 1;
        a = b;
      end
      h[i]    = a;
      hlen[i] = len;
    end
  endtask

  function automatic longint fmt(input int i, input longint y);
    int aw;
    longint v;
    logic [7:0] b8;
    aw = 8 + stg_of(i) * lg_of(i);
    v  = (y <<< (64 - aw)) >>> (64 - aw);
    v  = v >>> ((stg_of(i) - 1) * lg_of(i));
    b8 = v[7:0];
    return longint'($signed(b8));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      ph[i] = 0; t[i] = 0; exp_out[i] = 0; exp_val[i] = 0;
      accepts[i] = 0; beats[i] = 0;
      for (int j = 0; j < 64; j++) hist[i][j] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      if (ph[i] != 0 || din_valid) begin
        bit acc;
        longint y;
        acc = (ph[i] == 0) && din_valid;
        t[i]++;
        hist[i][t[i] % 64] = acc ? longint'($signed(din)) : 0;
        if (acc) accepts[i]++;
        y = 0;
        for (int m = 0; m < hlen[i]; m++) begin
          int k;
          k = t[i] - stg_of(i) - 1 - m;
          if (k >= 1) y += h[i][m] * hist[i][k % 64];
        end
        exp_out[i] = fmt(i, y);
        exp_val[i] = 1'b1;
        ph[i]      = (ph[i] + 1) % rate_of(i);
      end else begin
        exp_val[i] = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic [7:0] v, input logic vl);
    din = v;
    din_valid = vl;
    #1;
    for (int i = 0; i < NI; i++) check($sformatf("in_ready[%0d]", i), drdy[i], ph[i] == 0);
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("out_valid[%0d]", i), dval[i], exp_val[i]);
      check($sformatf("out[%0d]", i), $signed(dout[i]), exp_out[i]);
      if (dval[i]) beats[i]++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_out[%0d]", tag, i), $signed(dout[i]), 0);
      check($sformatf("%s_out_valid[%0d]", tag, i), dval[i], 0);
      check($sformatf("%s_in_ready[%0d]", tag, i), drdy[i], 0);
    end
  endtask

  initial begin
    longint imp [8];
    int     settle;

    build_h();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Impulse: 50 then zeros
    for (int k = 0; k < 40; k++) begin
      cycle((k == 0) ? 8'd50 : 8'd0, 1'b1);
      if (k < 8) imp[k] = $signed(dout[0]);
    end
    check("impulse_c1", imp[1], 0);
    for (int k = 2; k < 6; k++) check($sformatf("impulse_c%0d", k), imp[k], 50);
    check("impulse_c6", imp[6], 0);

    // DC 100
    settle = 0;
    for (int k = 0; k < 64; k++) begin
      cycle(8'd100, 1'b1);
      if ($signed(dout[1]) != 100) settle = k + 1;
    end
    check("dc100_settle_le11", settle <= 11, 1);
    check("dc100_s2", $signed(dout[1]), 100);

    // Stall of 5 cycles at phase 0
    for (int k = 0; k < 5; k++) begin
      cycle(8'd100, 1'b0);
      for (int i = 0; i < NI; i++) begin
        check($sformatf("stall_ready[%0d]", i), drdy[i], 1);
        check($sformatf("stall_valid[%0d]", i), dval[i], 0);
      end
    end
    for (int k = 0; k < 16; k++) cycle(8'd100, 1'b1);

    // Reset during phase 2
    cycle(8'd100, 1'b1);
    cycle(8'd100, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 16; k++) cycle(8'hD6, 1'b1);

    // DC -128, then +127/-128 alternating every 8 cycles
    for (int k = 0; k < 80; k++) cycle(8'h80, 1'b1);
    check("dcneg_s3", $signed(dout[2]), -128);
    for (int k = 0; k < 128; k++) cycle(((k / 8) % 2 == 0) ? 8'h7F : 8'h80, 1'b1);

    // Random handshake
    for (int k = 0; k < 1000; k++) cycle(8'($urandom), ($urandom_range(0, 2) != 0));
    for (int i = 0; i < NI; i++)
      check($sformatf("beats[%0d]", i), beats[i],
            accepts[i] * rate_of(i) - ((ph[i] == 0) ? 0 : rate_of(i) - ph[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
